switch_input_port: RTL and testbench

//  Producer side of the core's IN-instruction path. Samples the raw check-in button, debounces it,
//  and on each press captures the 16 switch values into a small FIFO. The core consumes words through a

---
 rtl/jups_io_pkg.sv | 9 +
 rtl/input_debouncer.sv | 66 ++++++
 rtl/switch_input_port.sv | 83 ++++++++
 tb/tb_switch_input_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jups_io_pkg.sv
// Shared constants for the board I/O path: default word width, debounce length and
// the electrical level of a pressed button.
package jups_io_pkg;

  localparam int unsigned IO_DATA_W           = 16;
  localparam int unsigned IO_DEBOUNCE_DEFAULT = 4;
  localparam logic        BUTTON_PRESSED      = 1'b0;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability counter for a raw active-low button; emits a
// one-cycle pulse when a press is accepted.
module input_debouncer
  import jups_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RawIn,
  output logic Level,
  output logic PressPulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [1:0]      fill_q, fill_d;
  logic            armed_q, armed_d;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], RawIn};
    fill_d  = {fill_q[0], 1'b1};
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    // A press held through reset must be released before another press can count;
    // fill_q marks that sync_q holds real samples rather than reset values.
    armed_d = armed_q | (fill_q[1] & (sync_q[1] != BUTTON_PRESSED));
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d    = sync_q[1];
      cnt_d   = '0;
      press_d = armed_q && (sync_q[1] == BUTTON_PRESSED);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign Level      = db_q;
  assign PressPulse = press_q;

endmodule

// File: rtl/switch_input_port.sv
// Captures the switch word on each debounced button press into a small first-word
// fall-through FIFO drained by the core's IN instruction.
module switch_input_port
  import jups_io_pkg::*;
#(
  parameter int unsigned DATA_W          = IO_DATA_W,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Button,
  input  logic [DATA_W-1:0]          Switches,
  input  logic                       InPop,
  output logic [DATA_W-1:0]          InData,
  output logic                       InValid,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              btn_level, btn_press;
  logic              push, full, pop_acc, push_acc;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .Clock      (Clock),
    .Reset      (Reset),
    .RawIn      (Button),
    .Level      (btn_level),
    .PressPulse (btn_press)
  );

  always_comb begin
    push     = btn_press && (btn_level == BUTTON_PRESSED);
    full     = (count_q == CntW'(DEPTH));
    pop_acc  = InPop && (count_q != '0);
    // When full, a coincident pop frees the slot the push needs.
    push_acc = push && (!full || pop_acc);
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (!push_acc && pop_acc) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q | (push && !push_acc);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push_acc) begin
      mem_q[wr_ptr_q] <= Switches;
    end
  end

  assign InValid  = (count_q != '0);
  assign InData   = InValid ? mem_q[rd_ptr_q] : '0;
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port: a table of press/pop/reset operations with
// hand-computed FIFO state, plus hand sequences for latency, glitch and reset-mid-press.
module tb_switch_input_port;

  localparam int OpRst   = 0;
  localparam int OpPress = 1;
  localparam int OpPop   = 2;

  typedef struct {
    int          op;
    logic [15:0] sw;
    logic        pop;
    int          exp_count;
    logic [15:0] exp_head;
    logic        exp_ovf;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Button;
  logic [15:0] Switches;
  logic        InPop;
  logic [15:0] InData;
  logic        InValid;
  logic [2:0]  Count;
  logic        Overflow;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 Clock = ~Clock;

  switch_input_port #(
    .DATA_W          (16),
    .DEPTH           (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Button   (Button),
    .Switches (Switches),
    .InPop    (InPop),
    .InData   (InData),
    .InValid  (InValid),
    .Count    (Count),
    .Overflow (Overflow)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (4) tick();
  endtask

  // Clean press of 9 samples; InPop optionally asserted in the push cycle (6 edges in).
  task automatic press(input logic [15:0] sw, input logic pop);
    Switches = sw;
    Button   = 1'b0;
    repeat (6) tick();
    InPop = pop;
    tick();
    InPop = 1'b0;
    repeat (2) tick();
    Button = 1'b1;
    repeat (8) tick();
  endtask

  task automatic pop_one();
    InPop = 1'b1;
    tick();
    InPop = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [15:0] head,
                           input logic ovf);
    chk({tag, " count"}, 32'(Count), 32'(cnt));
    chk({tag, " valid"}, 32'(InValid), 32'(cnt != 0));
    chk({tag, " ovf"}, 32'(Overflow), 32'(ovf));
    if (cnt != 0) chk({tag, " head"}, 32'(InData), 32'(head));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b1;
    Button   = 1'b1;
    Switches = '0;
    InPop    = 1'b0;
    tick();

    // Five presses overflow; pops drain in order; then full FIFO with push+pop;
    // then pops on empty and push+pop on empty.
    vecs.push_back('{OpRst,   16'h0000, 1'b0, 0, 16'h0000, 1'b0});
    vecs.push_back('{OpPress, 16'h0001, 1'b0, 1, 16'h0001, 1'b0});
    vecs.push_back('{OpPress, 16'h0002, 1'b0, 2, 16'h0001, 1'b0});
    vecs.push_back('{OpPress, 16'h0003, 1'b0, 3, 16'h0001, 1'b0});
    vecs.push_back('{OpPress, 16'h0004, 1'b0, 4, 16'h0001, 1'b0});
    vecs.push_back('{OpPress, 16'h0005, 1'b0, 4, 16'h0001, 1'b1});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 3, 16'h0002, 1'b1});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 2, 16'h0003, 1'b1});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 1, 16'h0004, 1'b1});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 0, 16'h0000, 1'b1});
    vecs.push_back('{OpRst,   16'h0000, 1'b0, 0, 16'h0000, 1'b0});
    vecs.push_back('{OpPress, 16'h0010, 1'b0, 1, 16'h0010, 1'b0});
    vecs.push_back('{OpPress, 16'h0011, 1'b0, 2, 16'h0010, 1'b0});
    vecs.push_back('{OpPress, 16'h0012, 1'b0, 3, 16'h0010, 1'b0});
    vecs.push_back('{OpPress, 16'h0013, 1'b0, 4, 16'h0010, 1'b0});
    vecs.push_back('{OpPress, 16'h0014, 1'b1, 4, 16'h0011, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 3, 16'h0012, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 2, 16'h0013, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 1, 16'h0014, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 0, 16'h0000, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 0, 16'h0000, 1'b0});
    vecs.push_back('{OpPop,   16'h0000, 1'b0, 0, 16'h0000, 1'b0});
    vecs.push_back('{OpPress, 16'h0015, 1'b1, 1, 16'h0015, 1'b0});

    // Reset state and first-press latency.
    do_reset();
    chk("reset count", 32'(Count), 32'd0);
    chk("reset valid", 32'(InValid), 32'd0);
    chk("reset data", 32'(InData), 32'd0);
    chk("reset ovf", 32'(Overflow), 32'd0);
    Switches = 16'h00A5;
    Button   = 1'b0;
    repeat (6) tick();
    chk("latency valid@6", 32'(InValid), 32'd0);
    tick();
    chk("latency valid@7", 32'(InValid), 32'd1);
    chk("latency data", 32'(InData), 32'h00A5);
    chk("latency count", 32'(Count), 32'd1);
    repeat (13) tick();
    Button = 1'b1;
    repeat (8) tick();
    chk("held press single push", 32'(Count), 32'd1);
    pop_one();
    chk("pop to empty", 32'(Count), 32'd0);

    // Three-sample glitch must not push.
    Button = 1'b0;
    repeat (3) tick();
    Button = 1'b1;
    repeat (10) tick();
    chk("glitch count", 32'(Count), 32'd0);
    chk("glitch valid", 32'(InValid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OpRst:   do_reset();
        OpPress: press(vecs[i].sw, vecs[i].pop);
        default: pop_one();
      endcase
      chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_head, vecs[i].exp_ovf);
    end

    // Two words stored with Overflow set, then reset during a held press.
    do_reset();
    for (int i = 0; i < 5; i++) press(16'h0020 + 16'(i), 1'b0);
    pop_one();
    pop_one();
    chk_state("pre-reset", 2, 16'h0022, 1'b1);
    Button = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid-press reset count", 32'(Count), 32'd0);
    chk("mid-press reset valid", 32'(InValid), 32'd0);
    chk("mid-press reset data", 32'(InData), 32'd0);
    chk("mid-press reset ovf", 32'(Overflow), 32'd0);
    repeat (20) tick();
    chk("held through reset no push", 32'(Count), 32'd0);
    Button = 1'b1;
    repeat (8) tick();
    chk("release after reset no push", 32'(Count), 32'd0);
    press(16'h0033, 1'b0);
    chk_state("re-press", 1, 16'h0033, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
